// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller and the minute timer it drives:
// timer key codes, the timer wrap value and the controller state encoding.
package stopwatch_ctrl_pkg;

  localparam int unsigned MAX_TIME = 5999;

  localparam logic [1:0] KEY_UP   = 2'b00;
  localparam logic [1:0] KEY_CLR  = 2'b01;
  localparam logic [1:0] KEY_HOLD = 2'b10;
  localparam logic [1:0] KEY_DOWN = 2'b11;

  typedef enum logic [2:0] {
    StClear   = 3'd0,
    StIdle    = 3'd1,
    StRunUp   = 3'd2,
    StRunDown = 3'd3,
    StPause   = 3'd4,
    StAlarm   = 3'd5
  } state_e;

  function automatic logic [1:0] state_key(state_e st);
    logic [1:0] k;
    k = KEY_HOLD;
    unique case (st)
      StClear:   k = KEY_CLR;
      StRunUp:   k = KEY_UP;
      StRunDown: k = KEY_DOWN;
      default:   k = KEY_HOLD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, timer-feedback and mode-key bundle between the board/timer side (master)
// and the stopwatch controller (slave).
interface stopwatch_ctrl_if #(
  parameter int unsigned CNT_W = 14
);
  logic             btn_start;
  logic             btn_clear;
  logic             btn_dir;
  logic [CNT_W-1:0] timer_count;
  logic [1:0]       key;
  logic             running;
  logic             dir_down;
  logic             alarm;

  modport master (
    output btn_start, btn_clear, btn_dir, timer_count,
    input  key, running, dir_down, alarm
  );

  modport slave (
    input  btn_start, btn_clear, btn_dir, timer_count,
    output key, running, dir_down, alarm
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability filter and a one-cycle
// pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronized level has disagreed with the
  // accepted level; any agreement restarts the run.
  always_comb begin
    stable_d = stable_q;
    pulse_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns debounced buttons into the timer mode key,
// stops a down-count at zero and raises a timed alarm there.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 14,
  parameter int unsigned DB_CYCLES    = 3,
  parameter int unsigned ALARM_CYCLES = 50
) (
  input  logic           clk_in,
  input  logic           rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned AlmW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [AlmW-1:0] AlmLast = AlmW'(ALARM_CYCLES - 1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [AlmW-1:0]  alm_q, alm_d;
  logic             start_p, clr_p, dir_p;
  logic [CNT_W-1:0] count;
  logic             cnt_zero, cnt_one;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk_in (clk_in),
    .rst    (rst),
    .btn_i  (bus.btn_start),
    .pulse_o(start_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk_in (clk_in),
    .rst    (rst),
    .btn_i  (bus.btn_clear),
    .pulse_o(clr_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk_in (clk_in),
    .rst    (rst),
    .btn_i  (bus.btn_dir),
    .pulse_o(dir_p)
  );

  assign count    = bus.timer_count;
  assign cnt_zero = (count == '0);
  assign cnt_one  = (count == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    alm_d   = alm_q;
    if (clr_p) begin
      state_d = StClear;
      alm_d   = '0;
    end else begin
      unique case (state_q)
        StClear: state_d = StIdle;
        StIdle, StPause: begin
          // A start pulse masks a same-cycle dir pulse even when the start is rejected.
          if (start_p) begin
            if (!dir_q)         state_d = StRunUp;
            else if (!cnt_zero) state_d = StRunDown;
          end else if (dir_p) begin
            dir_d = ~dir_q;
          end
        end
        StRunUp: if (start_p) state_d = StPause;
        StRunDown: begin
          // The timer steps 1 -> 0 on this edge; holding from the next cycle stops the wrap.
          if (cnt_one || cnt_zero) begin
            state_d = StAlarm;
            alm_d   = AlmLast;
          end else if (start_p) begin
            state_d = StPause;
          end
        end
        StAlarm: begin
          if (start_p || alm_q == '0) state_d = StIdle;
          else                        alm_d   = alm_q - AlmW'(1);
        end
        default: state_d = StClear;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      dir_q   <= 1'b0;
      alm_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      alm_q   <= alm_d;
    end
  end

  assign bus.key      = state_key(state_q);
  assign bus.running  = (state_q == StRunUp) || (state_q == StRunDown);
  assign bus.dir_down = dir_q;
  assign bus.alarm    = (state_q == StAlarm);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with an attached behavioural minute timer and a
// rule-level reference model checked every cycle.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int CW = 14;
  localparam int DB = 3;
  localparam int AC = 50;
  localparam int MT = MAX_TIME;

  logic clk_in = 1'b0;
  logic rst;

  stopwatch_ctrl_if #(.CNT_W(CW)) bus ();

  stopwatch_ctrl #(
    .CNT_W       (CW),
    .DB_CYCLES   (DB),
    .ALARM_CYCLES(AC)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural timer driven by the controller's key, with a bench preload hook.
  logic [CW-1:0] tcount = '0;
  logic          preload_en = 1'b0;
  logic [CW-1:0] preload_val = '0;
  assign bus.timer_count = tcount;

  always @(posedge clk_in) begin
    if (preload_en) tcount <= preload_val;
    else begin
      case (bus.key)
        KEY_CLR:  tcount <= '0;
        KEY_UP:   tcount <= (int'(tcount) == MT) ? '0 : tcount + CW'(1);
        KEY_DOWN: tcount <= (tcount == '0) ? CW'(MT) : tcount - CW'(1);
        default:  tcount <= tcount;
      endcase
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buttons as sample histories, controller as rule table.
  typedef enum int {MClear, MIdle, MUp, MDown, MPause, MAlarm} mstate_t;
  mstate_t     m_st = MClear;
  bit          m_dir = 1'b0;
  int          m_entry = 0;
  int          cyc = 0;
  bit   [2:0]  m_stable = '0;
  bit   [2:0]  m_pend = '0;
  logic [31:0] rawh [3];
  logic [31:0] syh [3];

  function automatic logic [1:0] m_key(mstate_t s);
    case (s)
      MClear:  return 2'b01;
      MUp:     return 2'b00;
      MDown:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0]    raw;
    logic          s;
    bit            ok, sp, cp, dp;
    logic [CW-1:0] tc;
    cyc++;
    if (rst) begin
      m_st = MClear;
      m_dir = 1'b0;
      m_stable = '0;
      m_pend = '0;
      for (int b = 0; b < 3; b++) begin
        rawh[b] = '0;
        syh[b] = '0;
      end
    end else begin
      cp = m_pend[1];
      sp = m_pend[0];
      dp = m_pend[2];
      tc = tcount;
      if (cp) m_st = MClear;
      else begin
        case (m_st)
          MClear: m_st = MIdle;
          MIdle, MPause: begin
            if (sp) begin
              if (!m_dir)       m_st = MUp;
              else if (tc != 0) m_st = MDown;
            end else if (dp) m_dir = !m_dir;
          end
          MUp: if (sp) m_st = MPause;
          MDown: begin
            if (tc <= 1) begin
              m_st = MAlarm;
              m_entry = cyc;
            end else if (sp) m_st = MPause;
          end
          MAlarm: if (sp || (cyc - m_entry) == AC) m_st = MIdle;
          default: m_st = MClear;
        endcase
      end
      // A button is accepted once its last DB synchronized samples all differ.
      raw = {bus.btn_dir, bus.btn_clear, bus.btn_start};
      for (int b = 0; b < 3; b++) begin
        s = rawh[b][1];
        rawh[b] = {rawh[b][30:0], raw[b]};
        syh[b] = {syh[b][30:0], s};
        ok = 1'b1;
        for (int i = 0; i < DB; i++) if (syh[b][i] == m_stable[b]) ok = 1'b0;
        m_pend[b] = 1'b0;
        if (ok) begin
          m_stable[b] = !m_stable[b];
          m_pend[b] = m_stable[b];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  initial forever begin
    @(negedge clk_in);
    if (rst) begin
      check("model_key", 32'(bus.key), 32'(KEY_CLR));
      check("model_running", 32'(bus.running), 0);
      check("model_dir", 32'(bus.dir_down), 0);
      check("model_alarm", 32'(bus.alarm), 0);
    end else begin
      check("model_key", 32'(bus.key), 32'(m_key(m_st)));
      check("model_running", 32'(bus.running), 32'((m_st == MUp) || (m_st == MDown)));
      check("model_dir", 32'(bus.dir_down), 32'(m_dir));
      check("model_alarm", 32'(bus.alarm), 32'(m_st == MAlarm));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.btn_start = v;
      1:       bus.btn_clear = v;
      default: bus.btn_dir = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    tick(hold);
    set_btn(b, 1'b0);
    tick(8);
  endtask

  task automatic preload(input int v);
    preload_val = CW'(v);
    preload_en = 1'b1;
    tick();
    preload_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         prev, acnt, hold_left [3];
    bit         found;
    logic [CW-1:0] c0;
    int         exp_seq [4];
    exp_seq = '{3, 2, 1, 0};
    rst = 1'b1;
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_dir = 1'b0;

    // Reset and idle.
    tick(3);
    check("rst_key", 32'(bus.key), 32'h1);
    @(posedge clk_in);
    #1 rst = 1'b0;
    tick();
    check("post_rst_key", 32'(bus.key), 32'h1);
    check("post_rst_count", 32'(tcount), 0);
    check("post_rst_running", 32'(bus.running), 0);
    tick();
    check("idle_key", 32'(bus.key), 32'h2);

    // Up count: pulse becomes visible after 5 edges, state moves on the 6th.
    bus.btn_start = 1'b1;
    tick(5);
    check("start_latency_hold", 32'(bus.key), 32'h2);
    tick();
    check("start_run_up", 32'(bus.key), 32'h0);
    tick(4);
    bus.btn_start = 1'b0;
    tick(6);
    c0 = tcount;
    tick();
    check("up_increment", 32'(tcount), 32'(c0 + CW'(1)));
    bus.btn_start = 1'b1;
    tick(6);
    check("pause_key", 32'(bus.key), 32'h2);
    c0 = tcount;
    tick(3);
    check("pause_freeze", 32'(tcount), 32'(c0));
    bus.btn_start = 1'b0;
    tick(8);

    // Wrap 5999 -> 0 while running up.
    preload(MT - 2);
    bus.btn_start = 1'b1;
    prev = int'(tcount);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (i == 9) bus.btn_start = 1'b0;
      if (prev == MT) begin
        check("wrap_to_zero", 32'(tcount), 0);
        check("wrap_key_up", 32'(bus.key), 32'h0);
        found = 1'b1;
      end
      prev = int'(tcount);
    end
    check("wrap_seen", 32'(found), 1);
    bus.btn_start = 1'b0;
    tick(8);
    press(0, 10);
    press(1, 10);
    check("clear_zero", 32'(tcount), 0);
    check("clear_keeps_dir", 32'(bus.dir_down), 0);

    // Down to zero with alarm.
    press(2, 10);
    check("dir_toggle", 32'(bus.dir_down), 1);
    preload(3);
    bus.btn_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.key == KEY_DOWN) found = 1'b1;
    end
    check("down_started", 32'(found), 1);
    for (int i = 0; i < 4; i++) begin
      check("down_seq", 32'(tcount), 32'(exp_seq[i]));
      if (i < 3) tick();
    end
    acnt = 0;
    for (int i = 0; i < 80 && bus.alarm; i++) begin
      acnt++;
      check("alarm_hold_zero", 32'(tcount), 0);
      tick();
    end
    bus.btn_start = 1'b0;
    check("alarm_len", 32'(acnt), 32'(AC));
    check("alarm_exit_key", 32'(bus.key), 32'h2);
    check("alarm_exit_count", 32'(tcount), 0);
    tick(8);

    // Zero-count start reject.
    press(0, 10);
    check("zero_reject_key", 32'(bus.key), 32'h2);
    check("zero_reject_alarm", 32'(bus.alarm), 0);
    check("zero_reject_running", 32'(bus.running), 0);

    // Dir ignored while running; clear beats a same-cycle start.
    press(2, 10);
    check("dir_back_up", 32'(bus.dir_down), 0);
    press(0, 10);
    check("sim_run_up", 32'(bus.key), 32'h0);
    press(2, 10);
    check("dir_ignored_run", 32'(bus.dir_down), 0);
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    tick(5);
    check("sim_before", 32'(bus.key), 32'h0);
    tick();
    check("sim_clear", 32'(bus.key), 32'h1);
    tick();
    check("sim_idle", 32'(bus.key), 32'h2);
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    tick(8);

    // Glitches shorter than the filter window.
    bus.btn_start = 1'b1;
    tick();
    bus.btn_start = 1'b0;
    tick(3);
    bus.btn_start = 1'b1;
    tick(2);
    bus.btn_start = 1'b0;
    tick(8);
    check("glitch_no_start", 32'(bus.key), 32'h2);

    // Asynchronous reset in the middle of a down count.
    press(2, 10);
    preload(100);
    bus.btn_start = 1'b1;
    tick(6);
    check("pre_rst_down", 32'(bus.key), 32'h3);
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("async_rst_key", 32'(bus.key), 32'h1);
    check("async_rst_dir", 32'(bus.dir_down), 0);
    check("async_rst_running", 32'(bus.running), 0);
    bus.btn_start = 1'b0;
    tick(2);
    @(posedge clk_in);
    #1 rst = 1'b0;
    tick();
    check("rst_timer_zero", 32'(tcount), 0);
    tick(8);

    // Randomized button traffic, preloads and resets against the model.
    for (int b = 0; b < 3; b++) hold_left[b] = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      preload_en = 1'b0;
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          if (b == 1) set_btn(b, 1'($urandom_range(0, 5) == 0));
          else        set_btn(b, 1'($urandom_range(0, 1)));
          hold_left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(6, 20));
        end
        hold_left[b]--;
      end
      if ($urandom_range(0, 150) == 0) begin
        case ($urandom_range(0, 3))
          0:       preload_val = CW'($urandom_range(0, 3));
          1:       preload_val = CW'(MT - int'($urandom_range(0, 3)));
          2:       preload_val = CW'($urandom_range(0, MT));
          default: preload_val = CW'($urandom_range(4, 12));
        endcase
        preload_en = 1'b1;
      end
      if ($urandom_range(0, 700) == 0) begin
        preload_en = 1'b0;
        @(posedge clk_in);
        #2 rst = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 rst = 1'b0;
      end
    end
    preload_en = 1'b0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
